wb_arbiter2: RTL and testbench

Two-master round-robin Wishbone classic arbiter. It shares one Wishbone slave port between two masters, for example the ROM-to-LED mapper and a second bus master such as a CPU data port or a debug bridge. The grant is held for the whole `cyc` assertion of the winning master, so multi-access sequences stay atomic. An optional watchdog terminates stalled cycles with an error.

---
 rtl/wb_arbiter2_if.sv | 29 ++
 rtl/wb_arbiter2.sv | 120 ++++++++++++
 tb/tb_wb_arbiter2.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter2_if.sv
// Wishbone classic bus bundle shared by the masters and the slave of wb_arbiter2.
// The master modport drives the request; the slave modport drives the response.
interface wb_arbiter2_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   adr;
  logic [DW-1:0]   dat_w;
  logic [DW-1:0]   dat_r;
  logic [DW/8-1:0] sel;
  logic            we;
  logic            cyc;
  logic            stb;
  logic [2:0]      cti;
  logic [1:0]      bte;
  logic            ack;
  logic            err;
  logic            rty;

  modport master (
    output adr, dat_w, sel, we, cyc, stb, cti, bte,
    input  dat_r, ack, err, rty
  );

  modport slave (
    input  adr, dat_w, sel, we, cyc, stb, cti, bte,
    output dat_r, ack, err, rty
  );
endinterface

// File: rtl/wb_arbiter2.sv
// Two-master round-robin Wishbone classic arbiter; the grant lasts for the whole cyc.
// Optional stall watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter2 #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk,
  input  logic            wb_rst_n,
  wb_arbiter2_if.slave    m0,
  wb_arbiter2_if.slave    m1,
  wb_arbiter2_if.master   s
);

  if (AW < 1 || DW < 8 || (DW % 8) != 0 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_param
    $error("wb_arbiter2: illegal parameter value");
  end

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t state;
  logic   last;
  logic   wd_fire;

`ifdef WB_ARB_TIMEOUT_EN
  logic [7:0] wd_cnt;
  logic       wd_stb;
  logic       wd_term;

  assign wd_stb  = (state == GNT0) ? m0.stb : m1.stb;
  assign wd_term = s.ack | s.err | s.rty;
  assign wd_fire = (state != IDLE) && (wd_cnt == 8'(TIMEOUT - 1));
`else
  assign wd_fire = 1'b0;
`endif

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
      wd_cnt <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          // On a tie the master other than the last winner takes the bus
          if (m0.cyc && (!m1.cyc || last)) begin
            state <= GNT0;
            last  <= 1'b0;
          end else if (m1.cyc) begin
            state <= GNT1;
            last  <= 1'b1;
          end
        end
        GNT0:    if (!m0.cyc || wd_fire) state <= IDLE;
        GNT1:    if (!m1.cyc || wd_fire) state <= IDLE;
        default: state <= IDLE;
      endcase
`ifdef WB_ARB_TIMEOUT_EN
      if (state == IDLE || wd_term) wd_cnt <= '0;
      else if (wd_stb)              wd_cnt <= wd_cnt + 8'd1;
`endif
    end
  end

  always_comb begin
    s.adr    = '0;
    s.dat_w  = '0;
    s.sel    = '0;
    s.we     = 1'b0;
    s.cyc    = 1'b0;
    s.stb    = 1'b0;
    s.cti    = '0;
    s.bte    = '0;
    m0.dat_r = '0;
    m0.ack   = 1'b0;
    m0.err   = 1'b0;
    m0.rty   = 1'b0;
    m1.dat_r = '0;
    m1.ack   = 1'b0;
    m1.err   = 1'b0;
    m1.rty   = 1'b0;
    unique case (state)
      GNT0: begin
        s.adr    = m0.adr;
        s.dat_w  = m0.dat_w;
        s.sel    = m0.sel;
        s.we     = m0.we;
        s.cti    = m0.cti;
        s.bte    = m0.bte;
        // A watchdog expiry aborts the bus cycle and substitutes an error
        s.cyc    = m0.cyc & ~wd_fire;
        s.stb    = m0.stb & ~wd_fire;
        m0.ack   = s.ack & ~wd_fire;
        m0.err   = s.err | wd_fire;
        m0.rty   = s.rty & ~wd_fire;
        m0.dat_r = s.dat_r;
        m1.dat_r = s.dat_r;
      end
      GNT1: begin
        s.adr    = m1.adr;
        s.dat_w  = m1.dat_w;
        s.sel    = m1.sel;
        s.we     = m1.we;
        s.cti    = m1.cti;
        s.bte    = m1.bte;
        s.cyc    = m1.cyc & ~wd_fire;
        s.stb    = m1.stb & ~wd_fire;
        m1.ack   = s.ack & ~wd_fire;
        m1.err   = s.err | wd_fire;
        m1.rty   = s.rty & ~wd_fire;
        m0.dat_r = s.dat_r;
        m1.dat_r = s.dat_r;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Self-checking bench for wb_arbiter2: routing table, directed corner cases,
// and a randomized run against a behavioural arbitration model.
module tb_wb_arbiter2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic wb_clk   = 1'b0;
  logic wb_rst_n = 1'b0;
  always #5 wb_clk = ~wb_clk;

  wb_arbiter2_if #(.AW(AW), .DW(DW)) m0_bus ();
  wb_arbiter2_if #(.AW(AW), .DW(DW)) m1_bus ();
  wb_arbiter2_if #(.AW(AW), .DW(DW)) s_bus ();

  wb_arbiter2 #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .wb_clk  (wb_clk),
    .wb_rst_n(wb_rst_n),
    .m0      (m0_bus),
    .m1      (m1_bus),
    .s       (s_bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    m0_bus.adr = '0; m0_bus.dat_w = '0; m0_bus.sel = '0; m0_bus.we = 0;
    m0_bus.cyc = 0;  m0_bus.stb = 0;    m0_bus.cti = '0; m0_bus.bte = '0;
    m1_bus.adr = '0; m1_bus.dat_w = '0; m1_bus.sel = '0; m1_bus.we = 0;
    m1_bus.cyc = 0;  m1_bus.stb = 0;    m1_bus.cti = '0; m1_bus.bte = '0;
    s_bus.dat_r = '0; s_bus.ack = 0; s_bus.err = 0; s_bus.rty = 0;
  endtask

  task automatic do_reset();
    @(negedge wb_clk);
    wb_rst_n = 1'b0;
    clear_inputs();
    @(negedge wb_clk);
    @(negedge wb_clk);
    wb_rst_n = 1'b1;
  endtask

  // Leaves the bus idle, then grants `who` alone
  task automatic acquire(input int who);
    @(negedge wb_clk);
    m0_bus.cyc = 0; m1_bus.cyc = 0;
    s_bus.ack = 0; s_bus.err = 0; s_bus.rty = 0;
    @(posedge wb_clk);
    @(negedge wb_clk);
    if (who == 0) begin m0_bus.cyc = 1; m0_bus.stb = 1; end
    else          begin m1_bus.cyc = 1; m1_bus.stb = 1; end
    @(posedge wb_clk);
  endtask

  typedef struct {
    int          who;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] sdat;
    logic        ack, err, rty;
    logic [5:0]  e_term;   // {m0 ack,err,rty, m1 ack,err,rty}
  } vec_t;

  vec_t vecs[8];

  // Reference model state
  int owner, prev, stall;
  int grants[$];

  function automatic logic own_cyc(input int o);
    return (o == 0) ? m0_bus.cyc : m1_bus.cyc;
  endfunction

  function automatic logic own_stb(input int o);
    return (o == 0) ? m0_bus.stb : m1_bus.stb;
  endfunction

  initial begin
    logic        fire, e_cyc, e_stb, e_a, e_e, e_r;
    logic [31:0] e_adr, e_dat;
    logic [9:0]  e_ctl;
    int          gnt, first_err, err_cnt;
    bit          seen;

    vecs[0] = '{0, 32'h9100_0000, 32'h1234_5678, 4'hF, 1, 3'd0, 2'd0, 32'h0000_0000, 1, 0, 0, 6'b100_000};
    vecs[1] = '{0, 32'h9100_0004, 32'hAAAA_5555, 4'h3, 1, 3'd2, 2'd1, 32'h1111_2222, 0, 1, 0, 6'b010_000};
    vecs[2] = '{0, 32'h9100_0008, 32'h0000_0000, 4'h1, 0, 3'd7, 2'd0, 32'hCAFE_F00D, 0, 0, 1, 6'b001_000};
    vecs[3] = '{0, 32'h0000_000C, 32'h5A5A_A5A5, 4'hC, 0, 3'd1, 2'd3, 32'h0BAD_CAFE, 1, 1, 1, 6'b111_000};
    vecs[4] = '{1, 32'h0800_0004, 32'h0000_0000, 4'hF, 0, 3'd0, 2'd0, 32'hDEAD_BEEF, 1, 0, 0, 6'b000_100};
    vecs[5] = '{1, 32'h0800_0008, 32'hFFFF_0001, 4'h8, 1, 3'd2, 2'd2, 32'h7654_3210, 0, 1, 0, 6'b000_010};
    vecs[6] = '{1, 32'h0800_000C, 32'h0F0F_0F0F, 4'h6, 1, 3'd7, 2'd1, 32'h0000_FFFF, 0, 0, 1, 6'b000_001};
    vecs[7] = '{1, 32'h0800_0010, 32'h1357_9BDF, 4'h2, 0, 3'd1, 2'd0, 32'h2468_ACE0, 0, 0, 0, 6'b000_000};

    // Reset values; a slave ack in IDLE must be discarded
    clear_inputs();
    #2;
    check("reset s_cyc/stb", {s_bus.cyc, s_bus.stb}, 2'b00);
    wb_rst_n = 1'b1;
    @(negedge wb_clk);
    s_bus.ack = 1; s_bus.dat_r = 32'hFFFF_FFFF;
    #1;
    check("idle terms", {m0_bus.ack, m0_bus.err, m0_bus.rty, m1_bus.ack, m1_bus.err, m1_bus.rty}, 6'b0);
    check("idle dat_o", {m0_bus.dat_r, m1_bus.dat_r}, 64'h0);
    check("idle s_adr", s_bus.adr, 32'h0);

    // Routing table: the granted master's request and terminations, the other isolated
    do_reset();
    gnt = -1;
    foreach (vecs[i]) begin
      if (gnt != vecs[i].who) begin
        acquire(vecs[i].who);
        gnt = vecs[i].who;
      end
      @(negedge wb_clk);
      if (vecs[i].who == 0) begin
        m0_bus.adr = vecs[i].adr; m0_bus.dat_w = vecs[i].dat; m0_bus.sel = vecs[i].sel;
        m0_bus.we = vecs[i].we; m0_bus.cti = vecs[i].cti; m0_bus.bte = vecs[i].bte;
        m1_bus.cyc = 1; m1_bus.stb = 1; m1_bus.adr = 32'hFFFF_0000; m1_bus.dat_w = 32'hEEEE_EEEE;
      end else begin
        m1_bus.adr = vecs[i].adr; m1_bus.dat_w = vecs[i].dat; m1_bus.sel = vecs[i].sel;
        m1_bus.we = vecs[i].we; m1_bus.cti = vecs[i].cti; m1_bus.bte = vecs[i].bte;
        m0_bus.cyc = 1; m0_bus.stb = 1; m0_bus.adr = 32'hFFFF_0000; m0_bus.dat_w = 32'hEEEE_EEEE;
      end
      s_bus.dat_r = vecs[i].sdat;
      s_bus.ack = vecs[i].ack; s_bus.err = vecs[i].err; s_bus.rty = vecs[i].rty;
      #1;
      check($sformatf("tbl%0d s_adr", i), s_bus.adr, vecs[i].adr);
      check($sformatf("tbl%0d s_dat", i), s_bus.dat_w, vecs[i].dat);
      check($sformatf("tbl%0d s_ctl", i), {s_bus.sel, s_bus.we, s_bus.cti, s_bus.bte, s_bus.cyc, s_bus.stb},
            {vecs[i].sel, vecs[i].we, vecs[i].cti, vecs[i].bte, 2'b11});
      check($sformatf("tbl%0d terms", i),
            {m0_bus.ack, m0_bus.err, m0_bus.rty, m1_bus.ack, m1_bus.err, m1_bus.rty}, vecs[i].e_term);
      check($sformatf("tbl%0d dat_o", i), {m0_bus.dat_r, m1_bus.dat_r}, {vecs[i].sdat, vecs[i].sdat});
    end

    // m0 alone writes 0x12345678 to 0x91000000; one cycle of arbitration latency
    do_reset();
    @(negedge wb_clk);
    m0_bus.cyc = 1; m0_bus.stb = 1; m0_bus.we = 1; m0_bus.sel = 4'hF;
    m0_bus.adr = 32'h9100_0000; m0_bus.dat_w = 32'h1234_5678;
    #1;
    check("wr s_cyc before edge", s_bus.cyc, 1'b0);
    @(posedge wb_clk); #1;
    check("wr s_cyc after edge", s_bus.cyc, 1'b1);
    check("wr s_dat", s_bus.dat_w, 32'h1234_5678);
    check("wr s_adr", s_bus.adr, 32'h9100_0000);
    @(negedge wb_clk);
    s_bus.ack = 1; #1;
    check("wr acks", {m0_bus.ack, m1_bus.ack}, 2'b10);
    @(negedge wb_clk);
    s_bus.ack = 0; #1;
    check("wr ack low", {m0_bus.ack, m1_bus.ack}, 2'b00);

    // Tie after reset goes to m0; one idle cycle before m1
    do_reset();
    @(negedge wb_clk);
    m0_bus.cyc = 1; m0_bus.stb = 1; m0_bus.adr = 32'h100;
    m1_bus.cyc = 1; m1_bus.stb = 1; m1_bus.adr = 32'h200;
    @(posedge wb_clk); #1;
    check("tie first", {s_bus.cyc, s_bus.adr}, {1'b1, 32'h100});
    @(negedge wb_clk);
    m0_bus.cyc = 0; m0_bus.stb = 0;
    @(posedge wb_clk); #1;
    check("tie idle gap", s_bus.cyc, 1'b0);
    @(posedge wb_clk); #1;
    check("tie second", {s_bus.cyc, s_bus.adr}, {1'b1, 32'h200});

    // Both hold cyc; each ends after 3 acks, then re-requests at once
    do_reset();
    grants.delete();
    @(negedge wb_clk);
    m0_bus.cyc = 1; m0_bus.stb = 1; m0_bus.adr = 32'h100;
    m1_bus.cyc = 1; m1_bus.stb = 1; m1_bus.adr = 32'h200;
    s_bus.ack = 1;
    for (int g = 0; g < 4; g++) begin
      seen = 0;
      for (int t = 0; t < 10 && !seen; t++) begin
        @(negedge wb_clk); #1;
        if (s_bus.cyc) seen = 1;
      end
      if (!seen) begin
        check("alt grant timeout", 1'b0, 1'b1);
        break;
      end
      gnt = (s_bus.adr == 32'h200) ? 1 : 0;
      grants.push_back(gnt);
      repeat (3) @(posedge wb_clk);
      @(negedge wb_clk);
      if (gnt == 0) m0_bus.cyc = 0; else m1_bus.cyc = 0;
      @(negedge wb_clk);
      m0_bus.cyc = 1; m1_bus.cyc = 1;
    end
    foreach (grants[i]) check($sformatf("alt grant%0d", i), grants[i], i % 2);
    s_bus.ack = 0;

    // m1 read; m0 requests mid-cycle and waits for the release
    do_reset();
    @(negedge wb_clk);
    m1_bus.cyc = 1; m1_bus.stb = 1; m1_bus.we = 0; m1_bus.adr = 32'h0800_0004;
    @(posedge wb_clk);
    @(negedge wb_clk);
    m0_bus.cyc = 1; m0_bus.stb = 1; m0_bus.adr = 32'h9100_0000;
    s_bus.dat_r = 32'hDEAD_BEEF; s_bus.ack = 1;
    #1;
    check("rd m1_dat", m1_bus.dat_r, 32'hDEAD_BEEF);
    check("rd acks", {m0_bus.ack, m1_bus.ack}, 2'b01);
    @(negedge wb_clk);
    s_bus.ack = 0; #1;
    check("rd still m1", s_bus.adr, 32'h0800_0004);
    @(negedge wb_clk);
    m1_bus.cyc = 0; m1_bus.stb = 0;
    @(posedge wb_clk); #1;
    check("rd idle gap", s_bus.cyc, 1'b0);
    @(posedge wb_clk); #1;
    check("rd m0 granted", {s_bus.cyc, s_bus.adr}, {1'b1, 32'h9100_0000});

    // Asynchronous reset while m0 strobes
    do_reset();
    @(negedge wb_clk);
    m0_bus.cyc = 1; m0_bus.stb = 1; m0_bus.adr = 32'h100;
    @(posedge wb_clk); #1;
    check("rst pre stb", s_bus.stb, 1'b1);
    #2 wb_rst_n = 1'b0;
    #1;
    check("rst async drop", {s_bus.cyc, s_bus.stb}, 2'b00);
    @(negedge wb_clk);
    m1_bus.cyc = 1; m1_bus.stb = 1; m1_bus.adr = 32'h200;
    wb_rst_n = 1'b1;
    #1;
    check("rst idle", s_bus.cyc, 1'b0);
    @(posedge wb_clk); #1;
    check("rst tie to m0", {s_bus.cyc, s_bus.adr}, {1'b1, 32'h100});

`ifdef WB_ARB_TIMEOUT_EN
    // Stalled slave: error pulse in the 8th granted cycle, then m1 granted
    do_reset();
    @(negedge wb_clk);
    m0_bus.cyc = 1; m0_bus.stb = 1; m0_bus.adr = 32'h100;
    m1_bus.cyc = 1; m1_bus.stb = 1; m1_bus.adr = 32'h200;
    @(posedge wb_clk);
    first_err = -1; err_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge wb_clk); #1;
      if (m0_bus.err) begin
        err_cnt++;
        if (first_err < 0) begin
          first_err = c;
          check("wd s_cyc/stb", {s_bus.cyc, s_bus.stb}, 2'b00);
        end
      end
      if (c == 9) check("wd m1 next", {s_bus.cyc, s_bus.adr}, {1'b1, 32'h200});
    end
    check("wd err cycle", first_err, TMO - 1);
    check("wd err width", err_cnt, 1);
`endif

    // Randomized traffic against the behavioural model
    do_reset();
    owner = -1; prev = 1; stall = 0;
    for (int n = 0; n < 600; n++) begin
      @(negedge wb_clk);
      if ($urandom_range(0, 4) == 0) m0_bus.cyc = ~m0_bus.cyc;
      if ($urandom_range(0, 4) == 0) m1_bus.cyc = ~m1_bus.cyc;
      m0_bus.stb = ($urandom_range(0, 3) != 0); m1_bus.stb = ($urandom_range(0, 3) != 0);
      m0_bus.adr = $urandom; m0_bus.dat_w = $urandom; m0_bus.sel = 4'($urandom);
      m1_bus.adr = $urandom; m1_bus.dat_w = $urandom; m1_bus.sel = 4'($urandom);
      m0_bus.we = 1'($urandom); m0_bus.cti = 3'($urandom); m0_bus.bte = 2'($urandom);
      m1_bus.we = 1'($urandom); m1_bus.cti = 3'($urandom); m1_bus.bte = 2'($urandom);
      s_bus.dat_r = $urandom;
      s_bus.ack = ($urandom_range(0, 3) == 0);
      s_bus.err = ($urandom_range(0, 9) == 0);
      s_bus.rty = ($urandom_range(0, 9) == 0);
      #1;
      fire = WD_ON && (owner >= 0) && (stall == TMO - 1);
      if (owner < 0) begin
        e_cyc = 0; e_stb = 0; e_adr = '0; e_dat = '0; e_ctl = '0;
        e_a = 0; e_e = 0; e_r = 0;
      end else begin
        e_cyc = own_cyc(owner) & ~fire;
        e_stb = own_stb(owner) & ~fire;
        e_adr = (owner == 0) ? m0_bus.adr : m1_bus.adr;
        e_dat = (owner == 0) ? m0_bus.dat_w : m1_bus.dat_w;
        e_ctl = (owner == 0) ? {m0_bus.sel, m0_bus.we, m0_bus.cti, m0_bus.bte}
                             : {m1_bus.sel, m1_bus.we, m1_bus.cti, m1_bus.bte};
        e_a = s_bus.ack & ~fire; e_e = s_bus.err | fire; e_r = s_bus.rty & ~fire;
      end
      check("rnd s_cyc/stb", {s_bus.cyc, s_bus.stb}, {e_cyc, e_stb});
      check("rnd s_adr", s_bus.adr, e_adr);
      check("rnd s_dat", s_bus.dat_w, e_dat);
      check("rnd s_ctl", {s_bus.sel, s_bus.we, s_bus.cti, s_bus.bte}, e_ctl);
      check("rnd m0 terms", {m0_bus.ack, m0_bus.err, m0_bus.rty},
            (owner == 0) ? {e_a, e_e, e_r} : 3'b000);
      check("rnd m1 terms", {m1_bus.ack, m1_bus.err, m1_bus.rty},
            (owner == 1) ? {e_a, e_e, e_r} : 3'b000);
      check("rnd dat_o", {m0_bus.dat_r, m1_bus.dat_r},
            (owner < 0) ? 64'h0 : {s_bus.dat_r, s_bus.dat_r});
      @(posedge wb_clk);
      if (owner >= 0) begin
        if (fire || !own_cyc(owner))                      owner = -1;
        else if (s_bus.ack || s_bus.err || s_bus.rty)     stall = 0;
        else if (own_stb(owner))                          stall++;
      end else begin
        stall = 0;
        if (m0_bus.cyc && m1_bus.cyc) owner = 1 - prev;
        else if (m0_bus.cyc)          owner = 0;
        else if (m1_bus.cyc)          owner = 1;
        if (owner >= 0) prev = owner;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
